apb_cmd_master: RTL and testbench

- Simple APB master feeding the control/status register slave on the same APB segment.
- Accepts host commands (read/write, 8-bit address, 32-bit data) through a valid/ready port and buffers them in a small FIFO.
- Issues APB SETUP/ACCESS transfers in order and returns one response pulse per command with read data.
- Lets firmware-side or test logic program the control word and poll status without hand-driving APB.

---
 rtl/apb_cmd_master_pkg.sv | 23 ++
 rtl/apb_cmd_fifo.sv | 53 +++++
 rtl/apb_cmd_master.sv | 146 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for the APB command master: bus widths, FSM encodings,
// command entry layout and the register map of the CSR slave on this segment.
package apb_cmd_master_pkg;

  localparam int APB_AW = 8;
  localparam int APB_DW = 32;
  localparam int CMD_W  = 1 + APB_AW + APB_DW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [APB_AW-1:0] CONTROL_0_ADDR = 8'h00;
  localparam logic [APB_AW-1:0] CONTROL_1_ADDR = 8'h10;
  localparam logic [APB_AW-1:0] STATUS_ADDR    = 8'h20;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap
// naturally. Push is honoured when full only if a pop happens in the same cycle.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 41
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB master draining a command FIFO into SETUP/ACCESS transfers, one response
// pulse per command. Define APB_PREADY_EN for pready wait states and a timeout.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [APB_AW-1:0]       cmd_addr,
  input  logic [APB_DW-1:0]       cmd_wdata,
  output logic                    rsp_valid,
  output logic [APB_DW-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [APB_AW-1:0]       paddr,
  output logic [APB_DW-1:0]       pwdata,
`ifdef APB_PREADY_EN
  input  logic                    pready,
`endif
  input  logic [APB_DW-1:0]       prdata,
  output logic [1:0]              dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_fifo_count
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_cmd_master: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // responses are single-cycle rsp_valid pulses with no backpressure, in order.
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  apb_cmd_t   head;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       run_q;
  logic       access_done;
  logic       timeout_hit;

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .pclk      (pclk),
    .presetn   (presetn),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_write, cmd_addr, cmd_wdata}),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (dbg_fifo_count)
  );

  // run_q keeps cmd_ready low while reset is held and for the release edge.
  assign cmd_ready = run_q && !fifo_full;
  assign dbg_state = state_q;

`ifdef APB_PREADY_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          rsp_err_q;

  assign timeout_hit = (state_q == ST_ACCESS) && !pready &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign access_done = (state_q == ST_ACCESS) && (pready || timeout_hit);
  assign rsp_err     = rsp_err_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_d == ST_SETUP) wait_cnt <= '0;
      else if (state_q == ST_ACCESS && !pready) wait_cnt <= wait_cnt + 1'b1;
      rsp_err_q <= access_done && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign access_done = (state_q == ST_ACCESS);
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (access_done) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      psel      <= (state_d != ST_IDLE);
      penable   <= (state_d == ST_ACCESS);
      rsp_valid <= access_done;
      // Address phase signals only change on a pop, so they hold through ACCESS.
      if (fifo_pop) begin
        pwrite <= head.write;
        paddr  <= head.addr;
        pwdata <= head.write ? head.wdata : '0;
      end
      if (access_done) rsp_rdata <= (pwrite || timeout_hit) ? '0 : prdata;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master with a small CSR slave model and a
// response scoreboard. Build with APB_PREADY_EN to also exercise the timeout.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  localparam int DEPTH          = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CW             = $clog2(DEPTH) + 1;

  logic          pclk;
  logic          presetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [7:0]    cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [7:0]    paddr;
  logic [31:0]   pwdata;
  logic          pready;
  logic [31:0]   prdata;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_fifo_count;

  logic [32:0]   exp_q[$];
  int            rsp_log[$];
  int            vectors      = 0;
  int            miscompares  = 0;
  int            cyc          = 0;
  int            psel_total   = 0;
  int            penable_total = 0;
  int            stall_total  = 0;
  int            max_count    = 0;
  logic [31:0]   model_ctrl1  = 32'h0;
  logic [31:0]   slave_ctrl1  = 32'h0;
  logic [31:0]   status_reg   = 32'hA5A5_0001;

  apb_cmd_master #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .paddr          (paddr),
    .pwdata         (pwdata),
`ifdef APB_PREADY_EN
    .pready         (pready),
`endif
    .prdata         (prdata),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // CSR slave: CONTROL_0 is a fixed pattern, CONTROL_1 is writable, STATUS is an input.
  always_comb begin
    case (paddr)
      CONTROL_0_ADDR: prdata = 32'hDEADBEEF;
      CONTROL_1_ADDR: prdata = slave_ctrl1;
      STATUS_ADDR:    prdata = status_reg;
      default:        prdata = 32'h0;
    endcase
  end

  always @(posedge pclk) begin
    if (psel && penable && pwrite && pready && paddr == CONTROL_1_ADDR) slave_ctrl1 <= pwdata;
  end

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      CONTROL_0_ADDR: return 32'hDEADBEEF;
      CONTROL_1_ADDR: return model_ctrl1;
      STATUS_ADDR:    return status_reg;
      default:        return 32'h0;
    endcase
  endfunction

  // Scoreboard / monitor: pops one expectation per response pulse.
  task automatic monitor_loop();
    logic [32:0] exp;
    forever begin
      @(negedge pclk);
      cyc++;
      if (psel) psel_total++;
      if (penable) penable_total++;
      if (int'(dbg_fifo_count) > max_count) max_count = int'(dbg_fifo_count);
      if (rsp_valid) begin
        vectors++;
        rsp_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: got err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== exp) begin
            miscompares++;
            $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                     rsp_err, rsp_rdata, exp[32], exp[31:0]);
          end
        end
      end
    end
  endtask

  // Driver: kind 0 = no response expected, 1 = normal, 2 = timeout.
  task automatic send_cmd(input logic w, input logic [7:0] a, input logic [31:0] d, input int kind);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && guard < 100) begin
      @(negedge pclk);
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
      cmd_valid = 1'b0;
    end else begin
      if (guard > 0) stall_total++;
      if (kind == 2) exp_q.push_back({1'b1, 32'h0});
      else if (kind == 1) begin
        if (w) begin
          exp_q.push_back({1'b0, 32'h0});
          if (a == CONTROL_1_ADDR) model_ctrl1 = d;
        end else begin
          exp_q.push_back({1'b0, model_read(a)});
        end
      end
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || dbg_state != ST_IDLE || dbg_fifo_count != '0) && guard < 400) begin
      @(negedge pclk);
      guard++;
    end
    if (guard >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    @(negedge pclk);
  endtask

  task automatic test_reset();
    presetn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    pready    = 1'b1;
    #12;
    vectors++;
    if ({psel, penable, pwrite, rsp_valid, cmd_ready, rsp_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b, required 000000", {psel, penable, pwrite, rsp_valid, cmd_ready, rsp_err});
    end
    vectors++;
    if ({paddr, pwdata, rsp_rdata} !== 72'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 0", {paddr, pwdata, rsp_rdata});
    end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    vectors++;
    if ({cmd_ready, dbg_state, dbg_fifo_count} !== {1'b1, ST_IDLE, CW'(0)}) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b state=%0d count=%0d, required 1/0/0", cmd_ready, dbg_state, dbg_fifo_count);
    end
  endtask

  task automatic test_single_read();
    int p0 = psel_total;
    send_cmd(1'b0, CONTROL_0_ADDR, 32'h0, 1);
    vectors++;
    if ({psel, penable} !== 2'b00) begin
      miscompares++;
      $display("FAIL lat_n0: psel/penable=%b, required 00", {psel, penable});
    end
    @(negedge pclk);
    vectors++;
    if ({psel, penable, pwrite, paddr} !== {2'b10, 1'b0, CONTROL_0_ADDR}) begin
      miscompares++;
      $display("FAIL lat_setup: psel/penable/pwrite/paddr=%b/%h, required 100/00", {psel, penable, pwrite}, paddr);
    end
    @(negedge pclk);
    vectors++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      miscompares++;
      $display("FAIL lat_access: psel/penable/rsp_valid=%b, required 110", {psel, penable, rsp_valid});
    end
    @(negedge pclk);
    vectors++;
    if ({psel, penable, rsp_valid} !== 3'b001) begin
      miscompares++;
      $display("FAIL lat_rsp: psel/penable/rsp_valid=%b, required 001", {psel, penable, rsp_valid});
    end
    wait_idle();
    vectors++;
    if (psel_total - p0 !== 2) begin
      miscompares++;
      $display("FAIL psel_width: got %0d cycles, required 2", psel_total - p0);
    end
  endtask

  task automatic test_write_read();
    send_cmd(1'b1, CONTROL_1_ADDR, 32'h12345678, 1);
    send_cmd(1'b0, CONTROL_1_ADDR, 32'h0, 1);
    wait_idle();
    vectors++;
    if (slave_ctrl1 !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ctrl1_write: slave got %h, required 12345678", slave_ctrl1);
    end
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h12345678}) begin
      miscompares++;
      $display("FAIL rdata_hold: valid=%b rdata=%h, required 0/12345678", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_status_unmapped();
    send_cmd(1'b0, STATUS_ADDR, 32'h0, 1);
    send_cmd(1'b0, 8'h44, 32'h0, 1);
    wait_idle();
    vectors++;
    if (rsp_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_hold: rdata=%h, required 0", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] addr_tab [4];
    int n0 = rsp_log.size();
    int p0 = psel_total;
    int s0 = stall_total;
    addr_tab[0] = CONTROL_0_ADDR;
    addr_tab[1] = STATUS_ADDR;
    addr_tab[2] = CONTROL_1_ADDR;
    addr_tab[3] = 8'h44;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) send_cmd(1'b1, CONTROL_1_ADDR, $urandom, 1);
      else send_cmd(1'b0, addr_tab[$urandom_range(0, 3)], 32'h0, 1);
    end
    wait_idle();
    vectors++;
    if (max_count !== DEPTH || stall_total - s0 < 1) begin
      miscompares++;
      $display("FAIL fifo_full: max count %0d stalls %0d, required %0d and >0", max_count, stall_total - s0, DEPTH);
    end
    vectors++;
    if (psel_total - p0 !== 20 || rsp_log.size() - n0 !== 10) begin
      miscompares++;
      $display("FAIL b2b_psel: psel cycles %0d responses %0d, required 20 and 10", psel_total - p0, rsp_log.size() - n0);
    end
    for (int k = n0 + 1; k < rsp_log.size(); k++) begin
      vectors++;
      if (rsp_log[k] - rsp_log[k-1] !== 2) begin
        miscompares++;
        $display("FAIL b2b_gap: response %0d gap %0d cycles, required 2", k - n0, rsp_log[k] - rsp_log[k-1]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int r0 = rsp_log.size();
    send_cmd(1'b1, CONTROL_1_ADDR, 32'hCAFEF00D, 0);
    @(negedge pclk);
    @(posedge pclk);
    #2;
    vectors++;
    if ({psel, penable} !== 2'b11) begin
      miscompares++;
      $display("FAIL abort_access: psel/penable=%b, required 11", {psel, penable});
    end
    presetn = 1'b0;
    #1;
    vectors++;
    if ({psel, penable, rsp_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_async: psel/penable/rsp_valid=%b, required 000", {psel, penable, rsp_valid});
    end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    repeat (3) @(negedge pclk);
    vectors++;
    if ({cmd_ready, dbg_fifo_count, dbg_state} !== {1'b1, CW'(0), ST_IDLE}) begin
      miscompares++;
      $display("FAIL abort_release: ready=%b count=%0d state=%0d, required 1/0/0", cmd_ready, dbg_fifo_count, dbg_state);
    end
    vectors++;
    if (slave_ctrl1 !== model_ctrl1 || rsp_log.size() !== r0) begin
      miscompares++;
      $display("FAIL abort_effect: ctrl1=%h responses=%0d, required %h and %0d", slave_ctrl1, rsp_log.size(), model_ctrl1, r0);
    end
  endtask

`ifdef APB_PREADY_EN
  task automatic test_timeout();
    int e0 = penable_total;
    pready = 1'b0;
    send_cmd(1'b0, CONTROL_0_ADDR, 32'h0, 2);
    wait_idle();
    vectors++;
    if (penable_total - e0 !== TIMEOUT_CYCLES) begin
      miscompares++;
      $display("FAIL timeout_len: ACCESS %0d cycles, required %0d", penable_total - e0, TIMEOUT_CYCLES);
    end
    pready = 1'b1;
    send_cmd(1'b0, CONTROL_0_ADDR, 32'h0, 1);
    wait_idle();
  endtask
`endif

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_single_read();
    test_write_read();
    test_status_unmapped();
    test_back_to_back();
    test_reset_abort();
`ifdef APB_PREADY_EN
    test_timeout();
`endif
    repeat (3) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
